// File: rtl/fifo_ctrl_pkg.sv
// Shared types and constants for the FIFO controller and its output buffer.
package fifo_ctrl_pkg;

    // Number of words the registered output buffer can hold.
    localparam int OUTBUF_DEPTH = 2;

    // Occupancy of the output buffer; the encoding is also the word count.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } buf_state_t;

    // Word count held in the output buffer for a given state.
    function automatic logic [1:0] buf_occupancy(input buf_state_t s);
        return 2'(s);
    endfunction

endpackage

// File: rtl/fifo_ctrl_if.sv
// Write-side and read-side streaming handshake of the FIFO controller.
// master: the producer/consumer environment; slave: the controller.
interface fifo_ctrl_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid
    );

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid
    );
endinterface

// File: rtl/fifo_ctrl_outbuf.sv
// Two-entry registered output buffer. The oldest word (head) is always the
// one presented on out_data; a capture fills the next free slot and a pop
// shifts the tail into the head.
module fifo_ctrl_outbuf
    import fifo_ctrl_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             capture_i,
    input  logic [WIDTH-1:0] cap_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] out_data_o,
    output logic             out_valid_o,
    output logic [1:0]       buf_count_o
);
    buf_state_t       state_q, state_d;
    logic [WIDTH-1:0] head_q, head_d;
    logic [WIDTH-1:0] tail_q, tail_d;
    logic             valid_q;

    // State and storage registers; reset empties the buffer and zeroes out_data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= EMPTY;
            head_q  <= '0;
            tail_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            valid_q <= (state_d != EMPTY);
        end
    end

    // Next state: capture adds one, pop removes one, both together keep the count.
    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        tail_d  = tail_q;
        case (state_q)
            EMPTY: begin
                if (capture_i) begin
                    head_d  = cap_data_i;
                    state_d = ONE;
                end
            end
            ONE: begin
                if (capture_i && pop_i) begin
                    head_d = cap_data_i;
                end else if (capture_i) begin
                    tail_d  = cap_data_i;
                    state_d = TWO;
                end else if (pop_i) begin
                    state_d = EMPTY;
                end
            end
            TWO: begin
                if (pop_i) begin
                    head_d = tail_q;
                    if (capture_i) begin
                        tail_d = cap_data_i;
                    end else begin
                        state_d = ONE;
                    end
                end
            end
            default: begin
                state_d = EMPTY;
            end
        endcase
    end

    assign out_data_o  = head_q;
    assign out_valid_o = valid_q;
    assign buf_count_o = buf_occupancy(state_q);

endmodule

// File: rtl/fifo_ctrl.sv
// FIFO controller in front of an external synchronous memory with a
// one-cycle read latency. Holds the write/read pointers, the memory word
// count and the fetch logic; a two-entry output buffer hides the read
// latency so a continuous stream runs at one word per cycle.
// Optional build macro FIFO_CTRL_LEVEL_EN adds a registered 'level' output
// giving the total number of words held (memory + in flight + buffer).
module fifo_ctrl
    import fifo_ctrl_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int ADDR  = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    fifo_ctrl_if.slave       bus,
    output logic [WIDTH-1:0] mem_write_data,
    output logic [ADDR-1:0]  mem_write_addr,
    output logic             mem_write_en,
    output logic [ADDR-1:0]  mem_read_addr,
    input  logic [WIDTH-1:0] mem_read_data,
    output logic             full,
    output logic             empty
`ifdef FIFO_CTRL_LEVEL_EN
    ,
    output logic [$clog2(DEPTH+3)-1:0] level
`endif
);
    localparam logic [ADDR:0] DEPTH_CNT = (ADDR+1)'(DEPTH);
    localparam logic [2:0]    OCC_MAX   = 3'(OUTBUF_DEPTH);

    logic [ADDR-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR:0]   mem_count_q, mem_count_d;
    logic            pend_q, pend_d;
    logic            full_q, full_d;
    logic            empty_q, empty_d;
    logic            push, pop, fetch;
    logic [1:0]      buf_count;
    logic [2:0]      occ;

    // Push is refused whenever the memory is full, even if a fetch frees a slot now.
    assign bus.in_ready   = !full_q && !rst;
    assign push           = bus.in_valid && bus.in_ready;
    assign pop            = bus.out_valid && bus.out_ready;

    assign mem_write_en   = push;
    assign mem_write_addr = wr_ptr_q;
    assign mem_write_data = bus.in_data;
    assign mem_read_addr  = rd_ptr_q;

    assign full           = full_q;
    assign empty          = empty_q;

    // Fetch decision and pointer/count updates. mem_count_q only reflects words
    // written on earlier edges, so a same-cycle push is never fetched.
    always_comb begin
        occ         = {1'b0, buf_count} + {2'b00, pend_q};
        fetch       = (mem_count_q != '0) &&
                      ((occ < OCC_MAX) || ((occ == OCC_MAX) && pop));
        wr_ptr_d    = push  ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d    = fetch ? rd_ptr_q + 1'b1 : rd_ptr_q;
        mem_count_d = mem_count_q + {{ADDR{1'b0}}, push} - {{ADDR{1'b0}}, fetch};
        pend_d      = fetch;
        full_d      = (mem_count_d == DEPTH_CNT);
        empty_d     = (mem_count_d == '0);
    end

    // Control registers; pend is cleared by reset so a returning read is dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            mem_count_q <= '0;
            pend_q      <= 1'b0;
            full_q      <= 1'b0;
            empty_q     <= 1'b1;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            mem_count_q <= mem_count_d;
            pend_q      <= pend_d;
            full_q      <= full_d;
            empty_q     <= empty_d;
        end
    end

    fifo_ctrl_outbuf #(
        .WIDTH (WIDTH)
    ) u_outbuf (
        .clk         (clk),
        .rst         (rst),
        .capture_i   (pend_q),
        .cap_data_i  (mem_read_data),
        .pop_i       (pop),
        .out_data_o  (bus.out_data),
        .out_valid_o (bus.out_valid),
        .buf_count_o (buf_count)
    );

`ifdef FIFO_CTRL_LEVEL_EN
    localparam int LVL_W = $clog2(DEPTH + 3);

    logic [LVL_W-1:0] level_q, level_d;
    logic [1:0]       buf_count_d;

    // Total words held after this edge: memory, read in flight, output buffer.
    always_comb begin
        buf_count_d = buf_count + {1'b0, pend_q} - {1'b0, pop};
        level_d     = LVL_W'(mem_count_d) + LVL_W'(pend_d) + LVL_W'(buf_count_d);
    end

    // Level register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level_q <= '0;
        end else begin
            level_q <= level_d;
        end
    end

    assign level = level_q;
`endif

endmodule

// File: tb/tb_fifo_ctrl.sv
// Testbench for fifo_ctrl (WIDTH=8, DEPTH=16) with a behavioural array memory
// (registered write, registered read). Reference model: an ordered queue of
// accepted words; a monitor pops and compares on every read-side handshake.
module tb_fifo_ctrl;
    localparam int WIDTH = 8;
    localparam int DEPTH = 16;
    localparam int ADDR  = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic [WIDTH-1:0] mem_write_data;
    logic [ADDR-1:0]  mem_write_addr;
    logic             mem_write_en;
    logic [ADDR-1:0]  mem_read_addr;
    logic [WIDTH-1:0] mem_read_data;
    logic             full;
    logic             empty;
`ifdef FIFO_CTRL_LEVEL_EN
    logic [$clog2(DEPTH+3)-1:0] level;
`endif

    fifo_ctrl_if #(.WIDTH(WIDTH)) bus_if ();

    fifo_ctrl #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .ADDR  (ADDR)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .bus            (bus_if.slave),
        .mem_write_data (mem_write_data),
        .mem_write_addr (mem_write_addr),
        .mem_write_en   (mem_write_en),
        .mem_read_addr  (mem_read_addr),
        .mem_read_data  (mem_read_data),
        .full           (full),
        .empty          (empty)
`ifdef FIFO_CTRL_LEVEL_EN
        ,
        .level          (level)
`endif
    );

    always #5 clk = ~clk;

    // Behavioural array memory: synchronous write, one-cycle registered read.
    logic [WIDTH-1:0] mem_arr [DEPTH];
    always @(posedge clk) begin
        if (mem_write_en) mem_arr[mem_write_addr] <= mem_write_data;
        mem_read_data <= mem_arr[mem_read_addr];
    end

    // Reference model and bookkeeping.
    logic [WIDTH-1:0] exp_q[$];
    int n_checks = 0;
    int n_pass   = 0;
    int rdy_mode = 0;   // 0: hold low, 1: hold high, 2: toggle, 3: random
    int cyc      = 0;
    int pop_cnt  = 0;
    int phase_pops  = 0;
    int phase_first = 0;
    int phase_last  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    endtask

    // Read-side consumer: drives out_ready shortly after each rising edge.
    initial begin : sink
        bus_if.out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       bus_if.out_ready = 1'b0;
                1:       bus_if.out_ready = 1'b1;
                2:       bus_if.out_ready = ~bus_if.out_ready;
                default: bus_if.out_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor: every read handshake must deliver the oldest outstanding word,
    // and a stalled word must not change.
    initial begin : monitor
        logic             stall_vld;
        logic [WIDTH-1:0] stall_data;
        stall_vld  = 1'b0;
        stall_data = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                stall_vld = 1'b0;
                continue;
            end
            if (stall_vld && bus_if.out_valid)
                check("stall_stable", 32'(bus_if.out_data), 32'(stall_data));
            stall_vld  = bus_if.out_valid && !bus_if.out_ready;
            stall_data = bus_if.out_data;
            if (bus_if.out_valid && bus_if.out_ready) begin
                if (exp_q.size() == 0) begin
                    check("spurious_word", 32'(bus_if.out_data), 32'hFFFF_FFFF);
                end else begin
                    check("out_data", 32'(bus_if.out_data), 32'(exp_q.pop_front()));
                end
                pop_cnt++;
                if (phase_pops == 0) phase_first = cyc;
                phase_last = cyc;
                phase_pops++;
            end
        end
    end

    // Offer one word for up to max_wait cycles; record it in the model if accepted.
    task automatic push_word(input logic [WIDTH-1:0] d, input int max_wait, output bit ok);
        bus_if.in_data  = d;
        bus_if.in_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < max_wait && !ok; i++) begin
            @(negedge clk);
            if (bus_if.in_ready) begin
                exp_q.push_back(d);
                ok = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        bus_if.in_valid = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || bus_if.out_valid) && n < 300) begin
            @(negedge clk);
            n++;
        end
        check({name, "_drained"}, 32'(n < 300), 32'd1);
        @(posedge clk);
        #1;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin : stim
        bit ok;
        int k, refused, pops0;
        bit got;
        rst             = 1'b1;
        bus_if.in_valid = 1'b0;
        bus_if.in_data  = '0;

        // Reset state
        @(negedge clk);
        check("rst_in_ready", 32'(bus_if.in_ready), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_out_valid", 32'(bus_if.out_valid), 32'd0);
        check("rst_out_data",  32'(bus_if.out_data),  32'd0);
        check("rst_empty",     32'(empty),            32'd1);
        check("rst_full",      32'(full),             32'd0);
        check("rst_in_ready_after", 32'(bus_if.in_ready), 32'd1);
        check("rst_mem_we",    32'(mem_write_en),     32'd0);
`ifdef FIFO_CTRL_LEVEL_EN
        check("rst_level", 32'(level), 32'd0);
`endif
        @(posedge clk);
        #1;

        // Single-word latency: visible two edges after the accepting edge
        rdy_mode = 1;
        @(posedge clk);
        #1;
        push_word(8'hA5, 4, ok);
        check("lat_accept", 32'(ok), 32'd1);
        k = 0;
        got = 1'b0;
        while (!got && k < 8) begin
            @(negedge clk);
            k++;
            got = bus_if.out_valid;
        end
        check("lat_edges", 32'(k), 32'd3);
        check("lat_empty", 32'(empty), 32'd1);
        wait_drain("lat");

        // Fill to capacity with the consumer stalled
        rdy_mode = 0;
        repeat (2) @(posedge clk);
        #1;
        refused = 0;
        for (int i = 0; i < DEPTH + 2; i++) begin
            push_word(8'(i), 1, ok);
            if (!ok) refused++;
        end
        check("fill_refused", 32'(refused), 32'd0);
        @(negedge clk);
        check("fill_full",     32'(full),             32'd1);
        check("fill_in_ready", 32'(bus_if.in_ready),  32'd0);
        check("fill_empty",    32'(empty),            32'd0);
`ifdef FIFO_CTRL_LEVEL_EN
        check("fill_level", 32'(level), 32'd18);
`endif
        @(posedge clk);
        #1;
        push_word(8'h12, 5, ok);
        check("fill_19th_refused", 32'(ok), 32'd0);
        pops0 = pop_cnt;
        rdy_mode = 1;
        wait_drain("fill");
        check("fill_pop_count", 32'(pop_cnt - pops0), 32'd18);

        // Sustained streaming: one word per cycle, pointers wrap many times
        phase_pops = 0;
        refused = 0;
        for (int i = 0; i < 256; i++) begin
            push_word(8'(i), 1, ok);
            if (!ok) refused++;
        end
        wait_drain("stream");
        check("stream_refused", 32'(refused), 32'd0);
        check("stream_pops",    32'(phase_pops), 32'd256);
        check("stream_no_bubble", 32'(phase_last - phase_first), 32'd255);

        // Toggling consumer: stalled words must hold
        rdy_mode   = 2;
        phase_pops = 0;
        push_word(8'h3C, 8, ok);
        for (int i = 0; i < 7; i++) push_word(8'($urandom), 8, ok);
        wait_drain("toggle");
        rdy_mode = 1;
        check("toggle_pops", 32'(phase_pops), 32'd8);

        // Random traffic on both sides
        rdy_mode = 3;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) != 0) begin
                push_word(8'($urandom), 1, ok);
            end else begin
                @(posedge clk);
                #1;
            end
        end
        rdy_mode = 1;
        wait_drain("random");

        // Reset mid-operation with a read in flight
        rdy_mode = 0;
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 5; i++) push_word(8'h51 + 8'(i), 2, ok);
        repeat (3) @(posedge clk);
        #1;
        rdy_mode = 1;
        k = 0;
        got = 1'b0;
        while (!got && k < 10) begin
            @(negedge clk);
            k++;
            got = bus_if.out_valid && bus_if.out_ready;
        end
        check("mid_pop_seen", 32'(got), 32'd1);
        @(posedge clk);
        rdy_mode = 0;
        #1 rst = 1'b1;
        exp_q.delete();
        @(negedge clk);
        check("mid_out_valid", 32'(bus_if.out_valid), 32'd0);
        check("mid_empty",     32'(empty),            32'd1);
        check("mid_full",      32'(full),             32'd0);
`ifdef FIFO_CTRL_LEVEL_EN
        check("mid_level", 32'(level), 32'd0);
`endif
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (3) @(negedge clk);
        check("mid_stale_read", 32'(bus_if.out_valid), 32'd0);
        @(posedge clk);
        #1;
        rdy_mode   = 1;
        phase_pops = 0;
        push_word(8'h77, 4, ok);
        wait_drain("post_rst");
        check("post_rst_pops", 32'(phase_pops), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
